tetris_vram_arb: RTL and testbench

Single-port VRAM arbiter/scheduler for the Tetris playfield memory. It shares one synchronous-read RAM between three users: the LCD renderer (read-only, absolute priority), the game logic (read/write, req/ack), and an internal clear-sweep engine that zeroes the field on new game. It sits inside tetris_top between the game FSM, the LCD pixel pipeline and the playfield RAM macro.

---
 rtl/tetris_vram_arb_pkg.sv | 14 +
 rtl/tetris_vram_arb_if.sv | 38 +++
 rtl/tetris_vram_arb_sweep.sv | 62 ++++++
 rtl/tetris_vram_arb.sv | 90 +++++++++
 tb/tb_tetris_vram_arb.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tetris_vram_arb_pkg.sv
// Shared constants and sweep FSM encoding for the playfield VRAM arbiter.
package tetris_vram_arb_pkg;
  localparam int VRAM_ADDR_W    = 9;
  localparam int VRAM_DATA_W    = 4;
  localparam int FIELD_DEPTH    = 512;
  localparam int STARVE_LIM_DEF = 1024;
  localparam int CELL_EMPTY     = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } sweep_state_t;
endpackage

// File: rtl/tetris_vram_arb_if.sv
// Client, status and RAM-side signals of the playfield VRAM arbiter.
interface tetris_vram_arb_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 4
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_rdata;
  logic              disp_rvalid;
  logic              game_req;
  logic              game_we;
  logic [ADDR_W-1:0] game_addr;
  logic [DATA_W-1:0] game_wdata;
  logic              game_ack;
  logic [DATA_W-1:0] game_rdata;
  logic              clr_start;
  logic              clr_busy;
  logic              clr_done;
  logic              game_starve;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  disp_req, disp_addr, game_req, game_we, game_addr, game_wdata,
           clr_start, ram_rdata,
    output disp_rdata, disp_rvalid, game_ack, game_rdata, clr_busy, clr_done,
           game_starve, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output disp_req, disp_addr, game_req, game_we, game_addr, game_wdata,
           clr_start, ram_rdata,
    input  disp_rdata, disp_rvalid, game_ack, game_rdata, clr_busy, clr_done,
           game_starve, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/tetris_vram_arb_sweep.sv
// Clear-sweep engine: walks addresses 0..DEPTH-1 whenever the display leaves the slot free.
//   state    | meaning
//   ST_IDLE  | no sweep, game accesses allowed
//   ST_SWEEP | writing empty cells, clr_busy high
//   ST_DONE  | one-cycle clr_done pulse, then back to idle
module tetris_vram_arb_sweep
  import tetris_vram_arb_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DEPTH  = FIELD_DEPTH
) (
  input  logic              mco,
  input  logic              res_n,
  input  logic              clr_start,
  input  logic              slot_free,
  output logic              sweep_wr,
  output logic              sweep_idle,
  output logic [ADDR_W-1:0] sweep_addr,
  output logic              clr_busy,
  output logic              clr_done
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  sweep_state_t     state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge mco or negedge res_n) begin
    if (!res_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (clr_start) begin
            state    <= ST_SWEEP;
            cnt      <= '0;
            clr_busy <= 1'b1;
          end
        end
        ST_SWEEP: begin
          if (slot_free) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(DEPTH - 1)) begin
              state    <= ST_DONE;
              clr_busy <= 1'b0;
              clr_done <= 1'b1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign sweep_wr   = (state == ST_SWEEP);
  assign sweep_idle = (state == ST_IDLE);
  assign sweep_addr = ADDR_W'(cnt);
endmodule

// File: rtl/tetris_vram_arb.sv
// Single-port VRAM arbiter: display > clear sweep > game, one RAM access per cycle.
module tetris_vram_arb
  import tetris_vram_arb_pkg::*;
#(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int DATA_W     = VRAM_DATA_W,
  parameter int DEPTH      = FIELD_DEPTH,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input logic mco,
  input logic res_n,
  tetris_vram_arb_if.slave bus
);
  localparam int WAIT_W = $clog2(STARVE_LIM + 1);

  logic              sweep_wr;
  logic              sweep_idle;
  logic [ADDR_W-1:0] sweep_addr;
  logic              game_issue;
  logic              game_wait;
  logic              game_rd_pend;
  logic [DATA_W-1:0] disp_hold;
  logic [DATA_W-1:0] game_hold;
  logic [WAIT_W-1:0] wait_cnt;

  tetris_vram_arb_sweep #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_sweep (
    .mco        (mco),
    .res_n      (res_n),
    .clr_start  (bus.clr_start),
    .slot_free  (!bus.disp_req),
    .sweep_wr   (sweep_wr),
    .sweep_idle (sweep_idle),
    .sweep_addr (sweep_addr),
    .clr_busy   (bus.clr_busy),
    .clr_done   (bus.clr_done)
  );

  // The ack cycle never issues: the requester is still dropping game_req then.
  assign game_issue = !bus.disp_req && sweep_idle && bus.game_req && !bus.game_ack;
  // The ack cycle is completion, not waiting, so it does not feed starvation.
  assign game_wait  = bus.game_req && !game_issue && !bus.game_ack;

  always_comb begin
    bus.ram_addr  = '0;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = '0;
    if (bus.disp_req) begin
      bus.ram_addr = bus.disp_addr;
    end else if (sweep_wr) begin
      bus.ram_addr  = sweep_addr;
      bus.ram_we    = 1'b1;
      bus.ram_wdata = DATA_W'(CELL_EMPTY);
    end else if (game_issue) begin
      bus.ram_addr  = bus.game_addr;
      bus.ram_we    = bus.game_we;
      bus.ram_wdata = bus.game_wdata;
    end
  end

  always_ff @(posedge mco or negedge res_n) begin
    if (!res_n) begin
      bus.disp_rvalid <= 1'b0;
      bus.game_ack    <= 1'b0;
      bus.game_starve <= 1'b0;
      game_rd_pend    <= 1'b0;
      disp_hold       <= '0;
      game_hold       <= '0;
      wait_cnt        <= '0;
    end else begin
      bus.disp_rvalid <= bus.disp_req;
      bus.game_ack    <= game_issue;
      game_rd_pend    <= game_issue && !bus.game_we;
      if (bus.disp_rvalid) disp_hold <= bus.ram_rdata;
      if (game_rd_pend)    game_hold <= bus.ram_rdata;
      if (game_issue) begin
        wait_cnt <= '0;
      end else if (game_wait && wait_cnt != WAIT_W'(STARVE_LIM)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (game_wait && wait_cnt >= WAIT_W'(STARVE_LIM - 1)) bus.game_starve <= 1'b1;
    end
  end

  // Read data passes straight through in its valid cycle and is held afterwards.
  assign bus.disp_rdata = bus.disp_rvalid ? bus.ram_rdata : disp_hold;
  assign bus.game_rdata = game_rd_pend    ? bus.ram_rdata : game_hold;
endmodule

// File: tb/tb_tetris_vram_arb.sv
// Directed bench for tetris_vram_arb with a transaction-level scoreboard model of the field memory.
module tb_tetris_vram_arb;
  localparam int AW    = 9;
  localparam int DW    = 4;
  localparam int DEPTH = 512;
  localparam int LIM   = 1024;

  logic mco;
  logic res_n;
  int   cyc;
  int   n_chk;
  int   n_pass;

  tetris_vram_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  tetris_vram_arb #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .DEPTH      (DEPTH),
    .STARVE_LIM (LIM)
  ) dut (
    .mco   (mco),
    .res_n (res_n),
    .bus   (bus)
  );

  initial mco = 1'b0;
  always #5 mco = ~mco;
  always @(posedge mco) cyc <= cyc + 1;

  // Playfield RAM macro: synchronous read, one cycle latency.
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge mco) begin
    if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= ram_mem[bus.ram_addr];
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard model: what the field should contain and what each client must see.
  logic [DW-1:0] m_mem   [DEPTH];
  bit            m_known [DEPTH];
  bit  m_rvalid, m_dknown, m_ack, m_grd, m_gknown, m_clearing, m_done, m_starve;
  logic [DW-1:0] m_drd, m_grdata;
  int  m_ptr, m_wait;

  always @(negedge mco) begin : cmp
    bit e_acc, e_we, g_iss, waiting, n_clearing, n_done;
    int e_addr, e_wd, n_ptr;
    if (!res_n) begin
      check("rst_ram_we", bus.ram_we, 0);
      check("rst_disp_rvalid", bus.disp_rvalid, 0);
      check("rst_game_ack", bus.game_ack, 0);
      check("rst_clr_busy", bus.clr_busy, 0);
      check("rst_clr_done", bus.clr_done, 0);
      check("rst_game_starve", bus.game_starve, 0);
      m_rvalid = 0; m_ack = 0; m_grd = 0; m_clearing = 0; m_done = 0;
      m_ptr = 0; m_wait = 0; m_starve = 0;
    end else begin
      e_acc = 0; e_we = 0; g_iss = 0; e_addr = 0; e_wd = 0;
      if (bus.disp_req) begin
        e_acc = 1; e_addr = int'(bus.disp_addr);
      end else if (m_clearing) begin
        e_acc = 1; e_we = 1; e_addr = m_ptr; e_wd = 0;
      end else if (!m_done && bus.game_req && !m_ack) begin
        g_iss = 1; e_acc = 1; e_we = bus.game_we;
        e_addr = int'(bus.game_addr); e_wd = int'(bus.game_wdata);
      end
      check("ram_we", bus.ram_we, int'(e_we));
      if (e_acc) check("ram_addr", int'(bus.ram_addr), e_addr);
      if (e_we) check("ram_wdata", int'(bus.ram_wdata), e_wd);
      check("disp_rvalid", bus.disp_rvalid, int'(m_rvalid));
      if (m_rvalid && m_dknown) check("disp_rdata", int'(bus.disp_rdata), int'(m_drd));
      check("game_ack", bus.game_ack, int'(m_ack));
      if (m_grd && m_gknown) check("game_rdata", int'(bus.game_rdata), int'(m_grdata));
      check("clr_busy", bus.clr_busy, int'(m_clearing));
      check("clr_done", bus.clr_done, int'(m_done));
      check("game_starve", bus.game_starve, int'(m_starve));

      waiting = bus.game_req && !g_iss && !m_ack;
      if (g_iss) m_wait = 0;
      else if (waiting && m_wait < LIM) m_wait++;
      if (m_wait >= LIM) m_starve = 1;

      m_rvalid = bus.disp_req;
      if (bus.disp_req) begin
        m_drd = m_mem[bus.disp_addr]; m_dknown = m_known[bus.disp_addr];
      end
      m_ack = g_iss;
      m_grd = g_iss && !bus.game_we;
      if (m_grd) begin
        m_grdata = m_mem[bus.game_addr]; m_gknown = m_known[bus.game_addr];
      end
      if (e_we) begin
        m_mem[e_addr] = DW'(e_wd); m_known[e_addr] = 1;
      end

      n_clearing = m_clearing; n_done = 0; n_ptr = m_ptr;
      if (m_clearing) begin
        if (!bus.disp_req) begin
          if (m_ptr == DEPTH - 1) begin n_clearing = 0; n_done = 1; end
          n_ptr = m_ptr + 1;
        end
      end else if (!m_done && bus.clr_start) begin
        n_clearing = 1; n_ptr = 0;
      end
      m_clearing = n_clearing; m_done = n_done; m_ptr = n_ptr;
    end
  end

  int done_cnt, done_cyc, ack_cyc, sweep_wr;
  always @(negedge mco) begin
    if (res_n) begin
      if (bus.clr_done) begin done_cnt++; done_cyc = cyc; end
      if (bus.game_ack) ack_cyc = cyc;
      if (bus.clr_busy && bus.ram_we) sweep_wr++;
    end
  end

  task automatic game_access(input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wd, output logic [DW-1:0] rd,
                             output int lat);
    bit got;
    @(posedge mco); #1;
    bus.game_req = 1'b1; bus.game_we = we; bus.game_addr = addr; bus.game_wdata = wd;
    lat = 0; rd = '0; got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge mco);
      lat++;
      if (bus.game_ack) begin rd = bus.game_rdata; got = 1; end
    end
    check("game_ack_timeout", int'(got), 1);
    @(posedge mco); #1;
    bus.game_req = 1'b0;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [DW-1:0] rd;
    int lat, s_cyc, d_before;
    res_n = 1'b0;
    bus.disp_req = 0; bus.disp_addr = '0; bus.game_req = 0; bus.game_we = 0;
    bus.game_addr = '0; bus.game_wdata = '0; bus.clr_start = 0;
    #2;
    check("reset_ram_addr", int'(bus.ram_addr), 0);
    check("reset_disp_rdata", int'(bus.disp_rdata), 0);
    check("reset_game_rdata", int'(bus.game_rdata), 0);
    repeat (3) @(posedge mco);
    #1 res_n = 1'b1;

    // Preload address 5 with 3, then display read of it.
    game_access(1'b1, 9'h005, 4'h3, rd, lat);
    @(posedge mco); #1;
    bus.disp_req = 1; bus.disp_addr = 9'h005;
    #1;
    check("disp_ram_addr", int'(bus.ram_addr), 5);
    check("disp_ram_we", int'(bus.ram_we), 0);
    @(posedge mco); #1;
    bus.disp_req = 0;
    @(negedge mco);
    check("disp_rvalid_lit", int'(bus.disp_rvalid), 1);
    check("disp_rdata_lit", int'(bus.disp_rdata), 3);
    check("disp_no_ack", int'(bus.game_ack), 0);

    game_access(1'b1, 9'h1FF, 4'hA, rd, lat);
    check("wr_ack_latency", lat, 2);
    game_access(1'b0, 9'h1FF, 4'h0, rd, lat);
    check("rd_ack_latency", lat, 2);
    check("rd_1ff_data", int'(rd), 10);

    // Game read blocked by three display cycles.
    fork
      game_access(1'b0, 9'h005, 4'h0, rd, lat);
      begin
        @(posedge mco); #1;
        bus.disp_req = 1; bus.disp_addr = 9'h1FF;
        @(posedge mco); #1; bus.disp_addr = 9'h005;
        @(posedge mco); #1; bus.disp_addr = 9'h000;
        @(posedge mco); #1; bus.disp_req = 0;
      end
    join
    check("blocked_ack_latency", lat, 5);
    check("blocked_rdata", int'(rd), 3);

    // Clear sweep with display on every second cycle and a game read held off.
    done_cnt = 0; sweep_wr = 0;
    @(posedge mco); #1;
    bus.clr_start = 1; s_cyc = cyc;
    @(posedge mco); #1;
    bus.clr_start = 0;
    fork
      begin
        for (int k = 1; k <= 1030; k++) begin
          bus.disp_req = k[0]; bus.disp_addr = AW'(k * 7);
          @(posedge mco); #1;
        end
        bus.disp_req = 0;
      end
      begin
        repeat (8) @(posedge mco);
        game_access(1'b0, 9'h005, 4'h0, rd, lat);
      end
    join
    check("sweep_write_count", sweep_wr, 512);
    check("sweep_done_count", done_cnt, 1);
    check("sweep_done_offset", done_cyc - s_cyc, 1025);
    check("sweep_game_ack_offset", ack_cyc - s_cyc, 1027);
    check("sweep_game_rdata", int'(rd), 0);

    // Starvation: display holds the port for LIM cycles.
    @(posedge mco); #1;
    bus.game_req = 1; bus.game_we = 0; bus.game_addr = 9'h1FF;
    bus.disp_req = 1; bus.disp_addr = 9'h010;
    for (int i = 0; i < LIM; i++) begin
      @(negedge mco);
      if (i == LIM - 1) check("starve_before_lim", int'(bus.game_starve), 0);
      @(posedge mco); #1;
    end
    bus.disp_req = 0;
    @(negedge mco);
    check("starve_at_lim", int'(bus.game_starve), 1);
    @(posedge mco); #1;
    @(negedge mco);
    check("starve_game_served", int'(bus.game_ack), 1);
    check("starve_game_rdata", int'(bus.game_rdata), 0);
    @(posedge mco); #1;
    bus.game_req = 0;
    repeat (3) @(posedge mco);
    #1 check("starve_sticky", int'(bus.game_starve), 1);

    // Reset in the middle of a sweep, then restart.
    @(posedge mco); #1;
    bus.clr_start = 1;
    @(posedge mco); #1;
    bus.clr_start = 0;
    repeat (100) @(posedge mco);
    #1;
    check("mid_sweep_addr", int'(bus.ram_addr), 100);
    check("mid_sweep_we", int'(bus.ram_we), 1);
    d_before = done_cnt;
    res_n = 1'b0;
    #1;
    check("rst_now_we", int'(bus.ram_we), 0);
    check("rst_now_busy", int'(bus.clr_busy), 0);
    check("rst_now_addr", int'(bus.ram_addr), 0);
    check("rst_now_starve", int'(bus.game_starve), 0);
    repeat (2) @(posedge mco);
    #1 res_n = 1'b1;
    repeat (3) @(posedge mco);
    #1 check("rst_no_done", done_cnt, d_before);
    bus.clr_start = 1;
    @(posedge mco); #1;
    bus.clr_start = 0;
    #1;
    check("restart_addr", int'(bus.ram_addr), 0);
    check("restart_we", int'(bus.ram_we), 1);
    check("restart_busy", int'(bus.clr_busy), 1);
    repeat (20) @(posedge mco);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
